mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Parametrised multi-master front end for the single-port synchronous SRAM. It replaces the point-to-point CPU-to-SRAM hookup so that NUM_CH masters (CPU fetch/data, DMA, debug) can share one SRAM. Each cycle it grants at most one request, by round-robin or fixed priority, and drives that request's address, data and write enable to the SRAM. It returns read data to the issuing master after a configurable read latency.

## Interface
Parameters:
- NUM_CH, 2: number of masters, 1..8.
- ADDR_W, 12: address width.
- DATA_W, 16: data width.
- SRAM_LAT, 1: SRAM read latency in cycles, 1..4.
- ARB_MODE, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low; clears all state while low.
- m_req  in  NUM_CH  per-master request; the master holds it, with m_we/m_addr/m_din, stable until m_gnt.
- m_we  in  NUM_CH  per-master write (1) / read (0).
- m_addr  in  NUM_CH*ADDR_W  per-master address; channel i occupies bits [i*ADDR_W +: ADDR_W].
- m_din  in  NUM_CH*DATA_W  per-master write data, packed the same way.
- m_gnt  out  NUM_CH  one-hot grant, combinational; the access is accepted in the cycle m_gnt is high.
- m_rvalid  out  NUM_CH  one-hot, registered; read data for that channel is on m_dout this cycle.
- m_dout  out  DATA_W  shared read data, qualified by m_rvalid.
- sram_addr  out  ADDR_W  address of the granted channel; 0 when idle.
- sram_din  out  DATA_W  write data of the granted channel; 0 when idle.
- sram_we  out  1  high when the granted access is a write.
- sram_en  out  1  high when any access is granted.
- sram_dout  in  DATA_W  SRAM read data, valid SRAM_LAT cycles after the access edge.

## Operation
- Arbitration is combinational from m_req and the priority pointer ptr. At most one m_gnt bit is high, and only for a channel with m_req high.
- Round-robin: the winner is the first requesting channel at or after ptr, scanning modulo NUM_CH. On a grant to channel i, ptr becomes (i+1) mod NUM_CH. ptr holds when there is no grant.
- Fixed priority: the lowest requesting index wins and ptr is unused.
- A single requesting channel is granted every cycle, giving one access per cycle.
- Read tracking: each granted read pushes {valid, channel id} into an SRAM_LAT-deep shift register. Writes and idle cycles push valid = 0.
- When the shift register's last stage is valid, m_rvalid[id] = 1 and m_dout = sram_dout.
- Reads and writes from different channels may interleave freely. Read data always returns in grant order.
- A write in cycle T followed by a read of the same address in cycle T+1 returns the new data (SRAM write-first).
- Reset values: ptr = 0, shift register all invalid, m_rvalid = 0. m_dout is a combinational pass-through of sram_dout, qualified by m_rvalid.
- While rst is low: m_gnt = 0, sram_en = 0, sram_we = 0.
- Reset mid-operation: all in-flight reads are dropped and no m_rvalid is issued for them. After reset release, arbitration restarts at channel 0.
- A deasserted m_req never receives a grant.
- Masters changing a request before its grant cause undefined behaviour. This is a bench assertion, not a hardware check.

## Timing
- Grant and SRAM command occur in the same cycle T (zero-cycle arbitration). The SRAM samples the command at the end of T.
- Read data: m_rvalid is high in cycle T+SRAM_LAT for exactly one cycle.
- Writes complete at the end of T and produce no response.
- Throughput is one access per cycle in aggregate. With all NUM_CH requesting continuously under round-robin, each channel is granted once every NUM_CH cycles.
- Fixed priority may starve high-index channels. This is documented and intentional.

## Structure
- mem_pkg holds:
  - default ADDR_W/DATA_W (12/16);
  - ARB_RR = 0 and ARB_FIXED = 1;
  - the channel-id width function clog2(NUM_CH), minimum 1.
- Sub-module rr_arbiter(NUM_CH, ARB_MODE) takes req and ptr and returns a one-hot gnt and the next ptr. It is reused later for the I/O bus.
- The top level contains the address/data muxes and the read-return shift register.

## Test plan
- Reset: hold rst low with all m_req high, then release → no m_gnt while low; after release the first grant goes to channel 0, m_rvalid = 0 throughout.
- Single master: ch0 writes 0xBEEF to 0x123, reads 0x123 next cycle (SRAM_LAT=1) → m_gnt[0] on both cycles, m_rvalid[0] one cycle after the read grant with m_dout = 0xBEEF.
- Round-robin contention: NUM_CH=3, all request continuous reads → grant sequence 0,1,2,0,1,2; each m_rvalid matches its granted channel, SRAM_LAT cycles later.
- Fixed priority: ARB_MODE=1, ch0 and ch1 both request for 4 cycles → ch0 granted all 4 cycles; ch1 granted on the cycle ch0 drops.
- Latency sweep: SRAM_LAT=3, back-to-back reads from ch1 then ch0 at addresses preloaded with 0x0011 and 0x0022 → m_rvalid[1] with 0x0011 at T+3, m_rvalid[0] with 0x0022 at T+4.
- Reset mid-read: SRAM_LAT=2, grant a read, then assert rst one cycle later → no m_rvalid ever appears for that read; ptr = 0 after release.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and helpers for the SRAM arbiter
// Purpose: default bus widths, arbitration mode codes and the channel-id
//          width helper used by mem_arbiter and rr_arbiter.
// Ports:   none (package).
package mem_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 16;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Width of a channel index; never less than one bit so single-master
    // builds still get a legal vector.
    function automatic int id_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - master-side and SRAM-side signal bundle for mem_arbiter
// Purpose: groups the per-master request/grant/response signals and the
//          SRAM command/data signals.
// Ports:   slave modport  - seen by mem_arbiter (requests in, grants/SRAM cmd out)
//          master modport - seen by masters and the SRAM model
interface mem_arbiter_if
    import mem_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic [NUM_CH-1:0]        m_req;
    logic [NUM_CH-1:0]        m_we;
    logic [NUM_CH*ADDR_W-1:0] m_addr;
    logic [NUM_CH*DATA_W-1:0] m_din;
    logic [NUM_CH-1:0]        m_gnt;
    logic [NUM_CH-1:0]        m_rvalid;
    logic [DATA_W-1:0]        m_dout;
    logic [ADDR_W-1:0]        sram_addr;
    logic [DATA_W-1:0]        sram_din;
    logic                     sram_we;
    logic                     sram_en;
    logic [DATA_W-1:0]        sram_dout;

    modport slave (
        input  m_req, m_we, m_addr, m_din, sram_dout,
        output m_gnt, m_rvalid, m_dout, sram_addr, sram_din, sram_we, sram_en
    );

    modport master (
        output m_req, m_we, m_addr, m_din, sram_dout,
        input  m_gnt, m_rvalid, m_dout, sram_addr, sram_din, sram_we, sram_en
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin / fixed-priority arbiter
// Purpose: picks at most one requester and returns the pointer to use after
//          that grant.
// Ports:   req_i - request vector
//          ptr_i - current round-robin pointer (ignored in fixed mode)
//          gnt_o - one-hot grant (all zero when nothing requests)
//          ptr_o - pointer after this grant (equals ptr_i when no grant)
module rr_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int ARB_MODE = ARB_RR
) (
    input  logic [NUM_CH-1:0]           req_i,
    input  logic [id_width(NUM_CH)-1:0] ptr_i,
    output logic [NUM_CH-1:0]           gnt_o,
    output logic [id_width(NUM_CH)-1:0] ptr_o
);

    localparam int PW = id_width(NUM_CH);

    logic found;

    // Round-robin is done as two constant-index passes: first the channels at
    // or above the pointer, then a wrap-around pass from channel 0. Any
    // channel at or above the pointer is taken in the first pass, so the
    // second one only ever picks channels below it.
    always_comb begin
        gnt_o = '0;
        ptr_o = ptr_i;
        found = 1'b0;
        if (ARB_MODE == ARB_RR) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!found && req_i[i] && (i >= int'(ptr_i))) begin
                    gnt_o[i] = 1'b1;
                    ptr_o    = (i == NUM_CH - 1) ? '0 : PW'(i + 1);
                    found    = 1'b1;
                end
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && req_i[i]) begin
                gnt_o[i] = 1'b1;
                if (ARB_MODE == ARB_RR) begin
                    ptr_o = (i == NUM_CH - 1) ? '0 : PW'(i + 1);
                end
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - multi-master front end for a single-port synchronous SRAM
// Purpose: grants one master per cycle, drives its command to the SRAM and
//          routes read data back after SRAM_LAT cycles.
// Ports:   clk - system clock
//          rst - asynchronous active-low reset
//          bus - mem_arbiter_if.slave: master requests/grants/read data and
//                the SRAM command and read-data signals
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SRAM_LAT = 1,
    parameter int ARB_MODE = ARB_RR
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int PW = id_width(NUM_CH);

    logic [PW-1:0]                    ptr_q;
    logic [PW-1:0]                    ptr_d;
    logic [NUM_CH-1:0]                gnt_raw;
    logic [NUM_CH-1:0]                gnt;
    logic [ADDR_W-1:0]                addr_mux;
    logic [DATA_W-1:0]                din_mux;
    logic                             we_mux;
    // Each stage holds a one-hot "read issued by channel i" vector, so the
    // last stage is already the registered m_rvalid.
    logic [SRAM_LAT-1:0][NUM_CH-1:0]  rv_q;

    rr_arbiter #(
        .NUM_CH   (NUM_CH),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .req_i (bus.m_req),
        .ptr_i (ptr_q),
        .gnt_o (gnt_raw),
        .ptr_o (ptr_d)
    );

    // No grant may leave the block while reset is asserted.
    assign gnt = gnt_raw & {NUM_CH{rst}};

    always_comb begin
        addr_mux = '0;
        din_mux  = '0;
        we_mux   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                addr_mux = bus.m_addr[i*ADDR_W +: ADDR_W];
                din_mux  = bus.m_din[i*DATA_W +: DATA_W];
                we_mux   = bus.m_we[i];
            end
        end
    end

    assign bus.m_gnt     = gnt;
    assign bus.sram_addr = addr_mux;
    assign bus.sram_din  = din_mux;
    assign bus.sram_we   = we_mux;
    assign bus.sram_en   = |gnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else if (|gnt) begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rv_q <= '0;
        end else begin
            rv_q[0] <= gnt & ~bus.m_we;
            for (int k = 1; k < SRAM_LAT; k++) begin
                rv_q[k] <= rv_q[k-1];
            end
        end
    end

    assign bus.m_rvalid = rv_q[SRAM_LAT-1];
    assign bus.m_dout   = (|rv_q[SRAM_LAT-1]) ? bus.sram_dout : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int NCH = 3;
    localparam int AW  = 12;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) bus_rr ();
    mem_arbiter_if #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) bus_fp ();

    mem_arbiter #(
        .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .SRAM_LAT(LAT), .ARB_MODE(ARB_RR)
    ) dut_rr (
        .clk (clk),
        .rst (rst),
        .bus (bus_rr)
    );

    mem_arbiter #(
        .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .SRAM_LAT(1), .ARB_MODE(ARB_FIXED)
    ) dut_fp (
        .clk (clk),
        .rst (rst),
        .bus (bus_fp)
    );

    // SRAM fixture: write-first, read data appears LAT cycles after the access edge
    logic [DW-1:0] sram_mem  [0:(1<<AW)-1];
    logic [DW-1:0] model_mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe   [0:LAT-1];

    always @(posedge clk) begin
        if (bus_rr.sram_en && bus_rr.sram_we) sram_mem[bus_rr.sram_addr] <= bus_rr.sram_din;
        rd_pipe[0] <= sram_mem[bus_rr.sram_addr];
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign bus_rr.sram_dout = rd_pipe[LAT-1];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pending transaction per master, held until granted
    logic [NCH-1:0] p_req;
    logic [NCH-1:0] p_we;
    logic [AW-1:0]  p_addr [NCH];
    logic [DW-1:0]  p_din  [NCH];
    logic [NCH-1:0] fp_req;

    typedef struct {
        int          ch;
        logic [DW-1:0] data;
        int          due;
    } rd_t;
    rd_t exp_q[$];

    task automatic new_txn(input int i);
        p_req[i]  = 1'b1;
        p_we[i]   = 1'($urandom_range(0, 1));
        p_addr[i] = AW'($urandom_range(0, 15));
        p_din[i]  = DW'($urandom);
    endtask

    task automatic drive();
        bus_rr.m_req = p_req;
        bus_rr.m_we  = p_we;
        for (int i = 0; i < NCH; i++) begin
            bus_rr.m_addr[i*AW +: AW] = p_addr[i];
            bus_rr.m_din[i*DW +: DW]  = p_din[i];
        end
        bus_fp.m_req = fp_req;
    endtask

    initial begin
        int          ptr;
        int          w;
        int          rst_hold;
        bit          did_rst;
        bit          last_rd;
        logic [NCH-1:0] last_gnt;
        logic [NCH-1:0] exp_gnt;
        logic [NCH-1:0] exp_rv;
        logic [DW-1:0]  exp_dout;

        ptr = 0; rst_hold = 0; did_rst = 1'b0; last_rd = 1'b0; last_gnt = '0;
        for (int a = 0; a < (1 << AW); a++) begin
            model_mem[a] = DW'($urandom);
            sram_mem[a]  = model_mem[a];
        end
        bus_fp.m_we = '0; bus_fp.m_addr = '0; bus_fp.m_din = '0; bus_fp.sram_dout = '0;
        for (int i = 0; i < NCH; i++) new_txn(i);
        fp_req = '1;
        drive();

        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            if (c == 4) rst = 1'b1;
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst = 1'b1;
            end else if (c >= 200 && !did_rst && last_rd) begin
                rst = 1'b0;
                rst_hold = 2;
                did_rst = 1'b1;
            end
            if (c >= 4) begin
                for (int i = 0; i < NCH; i++) begin
                    if (last_gnt[i]) p_req[i] = 1'b0;
                    if (!p_req[i] && $urandom_range(0, 3) != 0) new_txn(i);
                end
                fp_req = NCH'($urandom);
            end
            drive();

            @(negedge clk);
            if (!rst) begin
                check_eq("rst_gnt",    32'(bus_rr.m_gnt),    32'd0);
                check_eq("rst_en",     32'(bus_rr.sram_en),  32'd0);
                check_eq("rst_we",     32'(bus_rr.sram_we),  32'd0);
                check_eq("rst_rvalid", 32'(bus_rr.m_rvalid), 32'd0);
                check_eq("rst_fp_gnt", 32'(bus_fp.m_gnt),    32'd0);
                exp_q.delete();
                ptr = 0;
                last_gnt = '0;
                last_rd = 1'b0;
            end else begin
                exp_rv = '0;
                exp_dout = '0;
                if (exp_q.size() > 0 && exp_q[0].due == c) begin
                    exp_rv[exp_q[0].ch] = 1'b1;
                    exp_dout = exp_q[0].data;
                    void'(exp_q.pop_front());
                end
                check_eq("rvalid", 32'(bus_rr.m_rvalid), 32'(exp_rv));
                if (exp_rv != '0) check_eq("dout", 32'(bus_rr.m_dout), 32'(exp_dout));

                w = -1;
                for (int k = 0; k < NCH; k++) begin
                    if (w < 0 && p_req[(ptr + k) % NCH]) w = (ptr + k) % NCH;
                end
                exp_gnt = '0;
                if (w >= 0) exp_gnt[w] = 1'b1;
                check_eq("gnt", 32'(bus_rr.m_gnt), 32'(exp_gnt));
                check_eq("sram_en", 32'(bus_rr.sram_en), 32'(w >= 0));
                if (w >= 0) begin
                    check_eq("sram_addr", 32'(bus_rr.sram_addr), 32'(p_addr[w]));
                    check_eq("sram_din",  32'(bus_rr.sram_din),  32'(p_din[w]));
                    check_eq("sram_we",   32'(bus_rr.sram_we),   32'(p_we[w]));
                    ptr = (w + 1) % NCH;
                    if (p_we[w]) model_mem[p_addr[w]] = p_din[w];
                    else exp_q.push_back('{w, model_mem[p_addr[w]], c + LAT});
                    last_rd = !p_we[w];
                end else begin
                    check_eq("idle_addr", 32'(bus_rr.sram_addr), 32'd0);
                    check_eq("idle_din",  32'(bus_rr.sram_din),  32'd0);
                    last_rd = 1'b0;
                end
                last_gnt = exp_gnt;

                exp_gnt = '0;
                for (int i = NCH - 1; i >= 0; i--) begin
                    if (fp_req[i]) begin
                        exp_gnt = '0;
                        exp_gnt[i] = 1'b1;
                    end
                end
                check_eq("fp_gnt", 32'(bus_fp.m_gnt), 32'(exp_gnt));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
